// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the MEM-stage access controller.
// The MEM_TIMEOUT_EN macro controls the optional bus timeout in mem_access_ctrl.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } memState_t;

  // True when the address is not word-aligned
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return (lowBits & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter that bounds time spent waiting on the data bus.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  // Fires in the LIMIT-th enabled cycle after a clear
  assign expired = enable && (count == CW'(LIMIT - 1));

  // Count enabled cycles; saturate once expired so it never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access sequencer. Issues one bus transaction per
// load/store, freezes the pipeline until it completes, returns load data.
// Optional bus timeout: define MEM_TIMEOUT_EN.
import riscv_mem_pkg::*;

module mem_access_ctrl #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              err_o,
  output logic              bus_valid_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ready_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  memState_t state;
  logic      misaligned;
  logic      startReq;
  logic      timedOut;

  assign misaligned = isMisaligned(addr_i[1:0]);
  assign startReq   = (state == IDLE) && mem_req_i && !misaligned;

  // Freeze upstream registers from the first MEM cycle until the access resolves
  assign stall_o = ((state == IDLE) && mem_req_i) || (state == REQ) || (state == WAIT);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (startReq),
    .enable ((state == REQ) || (state == WAIT)),
    .expired(timedOut)
  );
`else
  // Without the timeout the FSM waits on the bus indefinitely
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign timedOut = 1'b0;
`endif

  // Access FSM with registered bus outputs, error pulse and load-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus_valid_o <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      load_data_o <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            if (misaligned) begin
              // Fault without touching the bus
              state <= DONE;
              err_o <= 1'b1;
            end else begin
              bus_valid_o <= 1'b1;
              bus_we_o    <= mem_write_i;
              bus_addr_o  <= addr_i;
              bus_wdata_o <= wdata_i;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // Completion wins over a timeout landing in the same cycle
          if (bus_ready_i) begin
            bus_valid_o <= 1'b0;
            if (bus_we_o) begin
              state <= DONE;
            end else if (bus_rvalid_i) begin
              load_data_o <= bus_rdata_i;
              state       <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (timedOut) begin
            bus_valid_o <= 1'b0;
            err_o       <= 1'b1;
            state       <= DONE;
          end
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            load_data_o <= bus_rdata_i;
            state       <= DONE;
          end else if (timedOut) begin
            err_o <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // Pipeline advances this cycle; the stale mem_req_i is ignored
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          bus_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_req_i;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        err_o;
  logic        bus_valid_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ready_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  int passed = 0;
  int total  = 0;

  mem_access_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req_i   (mem_req_i),
    .mem_write_i (mem_write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .load_data_o (load_data_o),
    .err_o       (err_o),
    .bus_valid_o (bus_valid_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ready_i (bus_ready_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled in the low phase
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_req_i = 1'b0; mem_write_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk);
    step();
    step();

    // Reset state
    chk("rst_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("rst_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_ldata", load_data_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("nomem_stall", {31'd0, stall_o}, 32'd0);

    // Store, ready on first REQ cycle
    mem_req_i = 1'b1; mem_write_i = 1'b1; addr_i = 32'h100; wdata_i = 32'hA5A5A5A5;
    bus_ready_i = 1'b1;
    #1;
    chk("st_idle_stall", {31'd0, stall_o}, 32'd1);
    chk("st_idle_valid", {31'd0, bus_valid_o}, 32'd0);
    step();
    chk("st_req_valid", {31'd0, bus_valid_o}, 32'd1);
    chk("st_req_we", {31'd0, bus_we_o}, 32'd1);
    chk("st_req_addr", bus_addr_o, 32'h100);
    chk("st_req_wdata", bus_wdata_o, 32'hA5A5A5A5);
    chk("st_req_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("st_done_stall", {31'd0, stall_o}, 32'd0);
    chk("st_done_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("st_done_err", {31'd0, err_o}, 32'd0);
    chk("st_done_ldata", load_data_o, 32'd0);
    mem_req_i = 1'b0; bus_ready_i = 1'b0;
    step();
    chk("st_idle2_stall", {31'd0, stall_o}, 32'd0);

    // Load: ready in 3rd REQ cycle, rvalid in 2nd WAIT cycle
    mem_req_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h200; wdata_i = 32'h0;
    #1;
    chk("ld_idle_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("ld_req1_valid", {31'd0, bus_valid_o}, 32'd1);
    chk("ld_req1_we", {31'd0, bus_we_o}, 32'd0);
    chk("ld_req1_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("ld_req2_valid", {31'd0, bus_valid_o}, 32'd1);
    chk("ld_req2_addr", bus_addr_o, 32'h200);
    chk("ld_req2_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("ld_req3_valid", {31'd0, bus_valid_o}, 32'd1);
    chk("ld_req3_stall", {31'd0, stall_o}, 32'd1);
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    chk("ld_wait1_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("ld_wait1_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("ld_wait2_stall", {31'd0, stall_o}, 32'd1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h12345678;
    step();
    bus_rvalid_i = 1'b0;
    chk("ld_done_ldata", load_data_o, 32'h12345678);
    chk("ld_done_stall", {31'd0, stall_o}, 32'd0);
    chk("ld_done_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("ld_done_err", {31'd0, err_o}, 32'd0);
    mem_req_i = 1'b0;
    step();
    chk("ld_noreissue", {31'd0, bus_valid_o}, 32'd0);

    // Misaligned load
    mem_req_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h203;
    #1;
    chk("mis_idle_stall", {31'd0, stall_o}, 32'd1);
    step();
    chk("mis_done_err", {31'd0, err_o}, 32'd1);
    chk("mis_done_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("mis_done_stall", {31'd0, stall_o}, 32'd0);
    chk("mis_done_ldata", load_data_o, 32'h12345678);
    mem_req_i = 1'b0;
    step();
    chk("mis_err_pulse", {31'd0, err_o}, 32'd0);
    chk("mis_idle_valid", {31'd0, bus_valid_o}, 32'd0);

    // Back-to-back load (zero-wait) then store; stray rvalid in IDLE is ignored
    mem_req_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h300;
    bus_ready_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEBABE;
    step();
    chk("b2b_ld_req_valid", {31'd0, bus_valid_o}, 32'd1);
    chk("b2b_ld_req_addr", bus_addr_o, 32'h300);
    chk("b2b_ld_req_ldata", load_data_o, 32'h12345678);
    step();
    chk("b2b_ld_done_ldata", load_data_o, 32'hCAFEBABE);
    chk("b2b_ld_done_valid", {31'd0, bus_valid_o}, 32'd0);
    mem_write_i = 1'b1; addr_i = 32'h304; wdata_i = 32'h0BADF00D;
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h11111111;
    #1;
    chk("b2b_done_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("b2b_st_idle_stall", {31'd0, stall_o}, 32'd1);
    chk("b2b_st_idle_valid", {31'd0, bus_valid_o}, 32'd0);
    step();
    chk("b2b_st_req_valid", {31'd0, bus_valid_o}, 32'd1);
    chk("b2b_st_req_we", {31'd0, bus_we_o}, 32'd1);
    chk("b2b_st_req_addr", bus_addr_o, 32'h304);
    chk("b2b_st_req_wdata", bus_wdata_o, 32'h0BADF00D);
    step();
    chk("b2b_st_done_stall", {31'd0, stall_o}, 32'd0);
    chk("b2b_st_done_ldata", load_data_o, 32'hCAFEBABE);
    mem_req_i = 1'b0; bus_ready_i = 1'b0;
    step();

    // Reset during WAIT; late rvalid dropped
    mem_req_i = 1'b1; mem_write_i = 1'b0; addr_i = 32'h400; bus_ready_i = 1'b1;
    step();
    chk("rw_req_valid", {31'd0, bus_valid_o}, 32'd1);
    step();
    bus_ready_i = 1'b0;
    chk("rw_wait_stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0; mem_req_i = 1'b0;
    step();
    chk("rw_rst_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("rw_rst_ldata", load_data_o, 32'd0);
    chk("rw_rst_stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    step();
    bus_rvalid_i = 1'b0;
    chk("rw_late_ldata", load_data_o, 32'd0);
    chk("rw_late_stall", {31'd0, stall_o}, 32'd0);
    chk("rw_late_valid", {31'd0, bus_valid_o}, 32'd0);
    step();

`ifdef MEM_TIMEOUT_EN
    // Store with ready never asserted: abort after 8 REQ cycles
    mem_req_i = 1'b1; mem_write_i = 1'b1; addr_i = 32'h500; wdata_i = 32'h55AA55AA;
    step();
    mem_req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_req_valid", {31'd0, bus_valid_o}, 32'd1);
      chk("to_req_stall", {31'd0, stall_o}, 32'd1);
      step();
    end
    chk("to_done_err", {31'd0, err_o}, 32'd1);
    chk("to_done_valid", {31'd0, bus_valid_o}, 32'd0);
    chk("to_done_stall", {31'd0, stall_o}, 32'd0);
    chk("to_done_ldata", load_data_o, 32'd0);
    step();
    chk("to_err_pulse", {31'd0, err_o}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
